// File: rtl/spi_master_shift_engine_pkg.sv
// Shared types and constants for the SPI master shift engine.
package spi_master_shift_engine_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        DONE
    } state_e;

    typedef logic [1:0] spi_mode_t;

    // SelectMode is packed as {CPOL,CPHA}.
    localparam spi_mode_t MODE0 = 2'b00;
    localparam spi_mode_t MODE1 = 2'b01;
    localparam spi_mode_t MODE2 = 2'b10;
    localparam spi_mode_t MODE3 = 2'b11;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_master_shift_engine_if.sv
// Load/receive handshake plus SPI pad signals of the shift engine.
interface spi_master_shift_engine_if
    import spi_master_shift_engine_pkg::*;
#(
    parameter int Size = 16
);
    spi_mode_t       SelectMode;
    logic            LsbFirst;
    logic            Load_Valid;
    logic            Load_Ready;
    logic [Size-1:0] Load_Data;
    logic            SCLK;
    logic            CS_n;
    logic            MOSI;
    logic            MISO;
    logic            Rx_Valid;
    logic [Size-1:0] Rx_Data;
    logic            Busy;

    // Engine side.
    modport master (
        input  SelectMode, LsbFirst, Load_Valid, Load_Data, MISO,
        output Load_Ready, SCLK, CS_n, MOSI, Rx_Valid, Rx_Data, Busy
    );

    // Front-end and pad side.
    modport slave (
        output SelectMode, LsbFirst, Load_Valid, Load_Data, MISO,
        input  Load_Ready, SCLK, CS_n, MOSI, Rx_Valid, Rx_Data, Busy
    );

endinterface

// File: rtl/spi_master_shift_engine_clk_divider.sv
// Tick generator: o_tick is high on every ClkDiv-th cycle after the last clear.
module spi_clk_divider #(
    parameter int ClkDiv = 4
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [CW-1:0] LAST = CW'(ClkDiv - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/spi_master_shift_engine.sv
// Full-duplex SPI master: serialises one Size-bit word per frame in any SPI mode,
// MSB- or LSB-first, and returns the word received on MISO with a one-cycle strobe.
module spi_master_shift_engine
    import spi_master_shift_engine_pkg::*;
#(
    parameter int Size   = 16,
    parameter int ClkDiv = 4
) (
    input logic                        CLK,
    input logic                        Reset_n,
    spi_master_shift_engine_if.master  bus
);
    localparam int CntW = $clog2(2 * Size);
    localparam logic [CntW-1:0] LAST_EDGE = CntW'(2 * Size - 1);

    state_e          r_state;
    state_e          w_next;
    logic            w_tick;
    logic            w_clear;
    logic            w_accept;
    logic            w_shift_tick;
    logic            w_leading;
    logic            w_sample;
    logic            w_advance;
    logic [CntW-1:0] r_edge;
    logic [Size-1:0] r_tx;
    logic [Size-1:0] r_rx;
    logic [Size-1:0] r_rx_data;
    logic            r_sclk;
    logic            r_cpha;
    logic            r_lsb;

    assign w_accept = (r_state == IDLE) && bus.Load_Valid;
    // Every state starts with a fresh divider period.
    assign w_clear  = (w_next != r_state);

    spi_clk_divider #(.ClkDiv(ClkDiv)) u_div (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = LEAD;
            LEAD:    if (w_tick) w_next = SHIFT;
            SHIFT:   if (w_tick && (r_edge == LAST_EDGE)) w_next = TRAIL;
            TRAIL:   if (w_tick) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.Load_Ready = (r_state == IDLE);
        bus.Busy       = (r_state != IDLE);
        bus.CS_n       = (r_state == IDLE) || (r_state == DONE);
        bus.Rx_Valid   = (r_state == DONE);
    end

    // Even edge index = leading SCLK edge; CPHA picks which parity samples and which shifts.
    assign w_shift_tick = (r_state == SHIFT) && w_tick;
    assign w_leading    = ~r_edge[0];
    assign w_sample     = w_shift_tick && (r_cpha ? !w_leading : w_leading);
    assign w_advance    = w_shift_tick && (r_cpha ? (w_leading && (r_edge != '0)) : !w_leading);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_edge    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_sclk    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_sclk <= bus.SelectMode[CPOL_BIT];
                r_edge <= '0;
                if (w_accept) begin
                    r_tx   <= bus.Load_Data;
                    r_cpha <= bus.SelectMode[CPHA_BIT];
                    r_lsb  <= bus.LsbFirst;
                    r_rx   <= '0;
                end
            end
            if (w_shift_tick) begin
                r_sclk <= ~r_sclk;
                r_edge <= r_edge + CntW'(1);
            end
            if (w_sample) begin
                r_rx <= r_lsb ? {bus.MISO, r_rx[Size-1:1]} : {r_rx[Size-2:0], bus.MISO};
            end
            if (w_advance) begin
                r_tx <= r_lsb ? (r_tx >> 1) : (r_tx << 1);
            end
            if ((r_state == TRAIL) && w_tick) begin
                r_rx_data <= r_rx;
            end
        end
    end

    assign bus.SCLK    = r_sclk;
    assign bus.MOSI    = r_lsb ? r_tx[0] : r_tx[Size-1];
    assign bus.Rx_Data = r_rx_data;

endmodule

// File: tb/tb_spi_master_shift_engine.sv
// Bench for spi_master_shift_engine: vector table per SPI mode, SPI slave model,
// scoreboard of expected frames, back-to-back, mid-frame reset and minimal-size cases.
module tb_spi_master_shift_engine;
    import spi_master_shift_engine_pkg::*;

    localparam int SIZE      = 16;
    localparam int CLKDIV    = 4;
    localparam int FRAME_LAT = 1 + CLKDIV * (2 * SIZE + 2);
    localparam int LAT_B     = 1 + 1 * (2 * 2 + 2);

    typedef struct {
        spi_mode_t   mode;
        logic        lsb;
        logic [15:0] tx;
        logic        loop;
        logic [15:0] miso;
        logic [15:0] exp_rx;
    } vec_t;

    typedef struct {
        logic [15:0] rx;
        logic [15:0] mosi;
        logic        cpol;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t        sb[$];
    spi_mode_t   sl_mode = MODE0;
    logic        sl_lsb = 1'b0;
    logic [15:0] sl_word = '0;
    logic        sl_loop = 1'b0;
    logic        sl_miso = 1'b0;
    logic        gap_chk = 1'b0;
    int          rises = 0;
    int          falls = 0;
    int          cs_high_run = 0;

    spi_master_shift_engine_if #(.Size(SIZE)) bus_a ();
    spi_master_shift_engine_if #(.Size(2))    bus_b ();

    spi_master_shift_engine #(.Size(SIZE), .ClkDiv(CLKDIV)) u_dut_a (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus_a)
    );

    spi_master_shift_engine #(.Size(2), .ClkDiv(1)) u_dut_b (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus_b)
    );

    assign bus_a.MISO = sl_loop ? bus_a.MOSI : sl_miso;
    assign bus_b.MISO = bus_b.MOSI;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic bit_of(input logic [15:0] w, input logic lsb, input int i);
        return lsb ? w[i] : w[15-i];
    endfunction

    // SPI slave model and scoreboard consumer, sampled mid-cycle.
    initial begin
        logic        cs_prev = 1'b1;
        logic        sclk_prev = 1'b0;
        logic        rxv_prev = 1'b0;
        logic        leading;
        logic [15:0] mosi_cap = '0;
        int          sbit = 0;
        int          mbit = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cs_prev   = 1'b1;
                sclk_prev = bus_a.SCLK;
                rxv_prev  = 1'b0;
                continue;
            end
            if (rxv_prev) check("rx_valid_width", 32'(bus_a.Rx_Valid), 32'(0));
            if (cs_prev && !bus_a.CS_n) begin
                if (gap_chk) check("cs_gap", 32'(cs_high_run), 32'(2));
                rises = 0; falls = 0; sbit = 0; mbit = 0; mosi_cap = '0;
                if (!sl_mode[CPHA_BIT]) begin
                    sl_miso = bit_of(sl_word, sl_lsb, 0);
                    sbit    = 1;
                end
            end
            cs_high_run = bus_a.CS_n ? cs_high_run + 1 : 0;
            if (!bus_a.CS_n && (bus_a.SCLK != sclk_prev)) begin
                leading = (sclk_prev == sl_mode[CPOL_BIT]);
                if (bus_a.SCLK) rises++;
                else            falls++;
                if (leading != sl_mode[CPHA_BIT]) begin
                    if (mbit < SIZE) mosi_cap[sl_lsb ? mbit : SIZE-1-mbit] = bus_a.MOSI;
                    mbit++;
                end else if (sbit < SIZE) begin
                    sl_miso = bit_of(sl_word, sl_lsb, sbit);
                    sbit++;
                end
            end
            sclk_prev = bus_a.SCLK;
            cs_prev   = bus_a.CS_n;
            if (bus_a.Rx_Valid) begin
                if (sb.size() == 0) begin
                    check("rx_unexpected", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("rx_data", 32'(bus_a.Rx_Data), 32'(e.rx));
                    check("latency", 32'(cyc - e.acc), 32'(FRAME_LAT));
                    check("mosi_word", 32'(mosi_cap), 32'(e.mosi));
                    check("rise_edges", 32'(rises), 32'(SIZE));
                    check("fall_edges", 32'(falls), 32'(SIZE));
                    check("sclk_at_done", 32'(bus_a.SCLK), 32'(e.cpol));
                    check("cs_at_done", 32'(bus_a.CS_n), 32'(1));
                end
            end
            rxv_prev = bus_a.Rx_Valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_accept(output bit ok);
        logic ready_before;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ready_before = bus_a.Load_Ready;
            @(posedge clk); #1;
            if (ready_before) begin
                ok = 1'b1;
                return;
            end
        end
        check("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic push_frame(input vec_t v);
        exp_t e;
        sl_mode = v.mode;
        sl_lsb  = v.lsb;
        sl_word = v.miso;
        sl_loop = v.loop;
        e.rx    = v.exp_rx;
        e.mosi  = v.tx;
        e.cpol  = v.mode[CPOL_BIT];
        e.acc   = cyc - 1;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) return;
            @(posedge clk); #1;
        end
        check("drain_timeout", 32'(sb.size()), 32'(0));
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        bus_a.SelectMode = v.mode;
        bus_a.LsbFirst   = v.lsb;
        repeat (2) @(posedge clk);
        #1;
        check("idle_sclk", 32'(bus_a.SCLK), 32'(v.mode[CPOL_BIT]));
        bus_a.Load_Data  = v.tx;
        bus_a.Load_Valid = 1'b1;
        wait_accept(ok);
        bus_a.Load_Valid = 1'b0;
        if (!ok) return;
        push_frame(v);
        // Mode, order and data changes after accept must not disturb the frame.
        bus_a.Load_Data  = ~v.tx;
        bus_a.SelectMode = ~v.mode;
        bus_a.LsbFirst   = ~v.lsb;
        wait_drain();
        @(posedge clk); #1;
    endtask

    vec_t vecs[8];

    initial begin
        bit          ok;
        int          n;
        logic [15:0] burst[3];
        vec_t        bv;

        vecs[0] = '{MODE0, 1'b0, 16'hA5C3, 1'b1, 16'h0000, 16'hA5C3};
        vecs[1] = '{MODE3, 1'b1, 16'h00FF, 1'b0, 16'h1234, 16'h1234};
        vecs[2] = '{MODE1, 1'b0, 16'h3C5A, 1'b0, 16'hFFFF, 16'hFFFF};
        vecs[3] = '{MODE2, 1'b0, 16'hC3A5, 1'b0, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{MODE1, 1'b1, 16'h8001, 1'b0, 16'h9669, 16'h9669};
        vecs[5] = '{MODE2, 1'b1, 16'h7E01, 1'b1, 16'h0000, 16'h7E01};
        vecs[6] = '{MODE0, 1'b1, 16'h0F0F, 1'b0, 16'hB00C, 16'hB00C};
        vecs[7] = '{MODE3, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'h0000};
        burst   = '{16'h1357, 16'hFACE, 16'h0001};

        bus_a.SelectMode = MODE0; bus_a.LsbFirst = 1'b0;
        bus_a.Load_Valid = 1'b0;  bus_a.Load_Data = '0;
        bus_b.SelectMode = MODE0; bus_b.LsbFirst = 1'b0;
        bus_b.Load_Valid = 1'b0;  bus_b.Load_Data = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_load_ready", 32'(bus_a.Load_Ready), 32'(1));
        check("rst_cs_n",       32'(bus_a.CS_n),       32'(1));
        check("rst_sclk",       32'(bus_a.SCLK),       32'(0));
        check("rst_mosi",       32'(bus_a.MOSI),       32'(0));
        check("rst_rx_valid",   32'(bus_a.Rx_Valid),   32'(0));
        check("rst_rx_data",    32'(bus_a.Rx_Data),    32'(0));
        check("rst_busy",       32'(bus_a.Busy),       32'(0));
        check("rst_b_cs_n",     32'(bus_b.CS_n),       32'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Load_Valid held high across three frames; Load_Data rewritten mid-frame.
        bus_a.SelectMode = MODE0;
        bus_a.LsbFirst   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus_a.Load_Data  = burst[0];
        bus_a.Load_Valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_accept(ok);
            if (!ok) break;
            bv = '{MODE0, 1'b0, burst[k], 1'b1, 16'h0000, burst[k]};
            push_frame(bv);
            if (k == 2) bus_a.Load_Valid = 1'b0;
            bus_a.Load_Data = 16'hDEAD ^ 16'(k);
            repeat (20) @(posedge clk);
            #1;
            if (k == 0) gap_chk = 1'b1;
            if (k < 2) bus_a.Load_Data = burst[k+1];
        end
        bus_a.Load_Valid = 1'b0;
        wait_drain();
        gap_chk = 1'b0;
        @(posedge clk); #1;

        // Reset asserted after SCLK edge 10 aborts the frame.
        bus_a.SelectMode = MODE0;
        bus_a.LsbFirst   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus_a.Load_Data  = 16'h5A5A;
        bus_a.Load_Valid = 1'b1;
        wait_accept(ok);
        bus_a.Load_Valid = 1'b0;
        if (ok) begin
            bv = '{MODE0, 1'b0, 16'h5A5A, 1'b1, 16'h0000, 16'h5A5A};
            push_frame(bv);
            n = 0;
            while ((rises + falls < 11) && (n < 400)) begin
                @(posedge clk); #1;
                n++;
            end
            check("edge10_reached", 32'(rises + falls >= 11), 32'(1));
            rst_n = 1'b0;
            #1;
            check("abort_cs_n",       32'(bus_a.CS_n),       32'(1));
            check("abort_sclk",       32'(bus_a.SCLK),       32'(0));
            check("abort_rx_valid",   32'(bus_a.Rx_Valid),   32'(0));
            check("abort_busy",       32'(bus_a.Busy),       32'(0));
            check("abort_load_ready", 32'(bus_a.Load_Ready), 32'(1));
            check("abort_rx_data",    32'(bus_a.Rx_Data),    32'(0));
            sb.delete();
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
        end
        bv = '{MODE0, 1'b0, 16'h6B2D, 1'b1, 16'h0000, 16'h6B2D};
        run_vec(bv);

        // Minimal engine: Size=2, ClkDiv=1, MISO looped to MOSI.
        bus_b.SelectMode = MODE0;
        bus_b.LsbFirst   = 1'b0;
        bus_b.Load_Data  = 2'b10;
        check("b_ready", 32'(bus_b.Load_Ready), 32'(1));
        bus_b.Load_Valid = 1'b1;
        @(posedge clk); #1;
        bus_b.Load_Valid = 1'b0;
        bus_b.Load_Data  = 2'b01;
        n = 0;
        while (!bus_b.Rx_Valid && (n < 50)) begin
            @(posedge clk); #1;
            n++;
        end
        check("b_latency", 32'(n + 1), 32'(LAT_B));
        check("b_rx_data", 32'(bus_b.Rx_Data), 32'(2'b10));
        check("b_cs_n_done", 32'(bus_b.CS_n), 32'(1));
        @(posedge clk); #1;
        check("b_rx_valid_width", 32'(bus_b.Rx_Valid), 32'(0));
        check("b_ready_after", 32'(bus_b.Load_Ready), 32'(1));

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
